// File: rtl/logic_shift_unit.sv
// logic_shift_unit
//   Sequenced 32-bit logic/shift execution stage.
//   - AND/OR/NOR/NOT complete in one cycle.
//   - SLL/SRL shift one bit per cycle, using OP2[4:0] as the shift amount.
//   - The result is registered and offered on a valid/ready handshake.
//
// Ports
//   CLK        system clock (rising edge)
//   RST        asynchronous, active-high reset
//   IN_VALID   request present on OPRN/OP1/OP2
//   IN_READY   unit can accept a request (IDLE)
//   OPRN       000 AND, 001 OR, 010 NOR, 011 NOT(OP1), 100 SLL, 101 SRL, 11x illegal
//   OP1        first operand / value to shift
//   OP2        second operand; OP2[4:0] is the shift amount for shifts
//   OUT_VALID  RESULT/ZERO valid (HOLD)
//   OUT_READY  consumer accepts the result
//   RESULT     registered result
//   ZERO       RESULT == 0
//
// state | meaning
// IDLE  | waiting for a request, IN_READY = 1
// SHIFT | iterative shift in progress, one bit per cycle
// HOLD  | result valid, waiting for OUT_READY
module logic_shift_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [2:0]            OPRN,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ZERO
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  dir_left_q, dir_left_d;

  // Gate primitive outputs
  logic [DATA_WIDTH-1:0] and_w, or_w, nor_w, not_w;
  logic [4:0]            shamt_w;

  assign and_w   = OP1 & OP2;
  assign or_w    = OP1 | OP2;
  assign nor_w   = ~(OP1 | OP2);
  assign not_w   = ~OP1;
  assign shamt_w = OP2[4:0];

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          state_d = ST_HOLD;
          case (OPRN)
            OP_AND: result_d = and_w;
            OP_OR:  result_d = or_w;
            OP_NOR: result_d = nor_w;
            OP_NOT: result_d = not_w;
            OP_SLL, OP_SRL: begin
              result_d   = OP1;
              cnt_d      = shamt_w;
              dir_left_d = (OPRN == OP_SLL);
              // A zero shift amount completes immediately with OP1 unchanged
              if (shamt_w != 5'd0) state_d = ST_SHIFT;
            end
            default: result_d = '0;
          endcase
        end
      end
      ST_SHIFT: begin
        if (dir_left_q) result_d = {result_q[DATA_WIDTH-2:0], 1'b0};
        else            result_d = {1'b0, result_q[DATA_WIDTH-1:1]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      cnt_q      <= 5'd0;
      dir_left_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_HOLD);
  assign RESULT    = result_q;
  assign ZERO      = (result_q == '0);

endmodule

// File: tb/tb_logic_shift_unit.sv
module tb_logic_shift_unit;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [2:0]  OPRN;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic        ZERO;

  int vectors;
  int miscompares;

  logic_shift_unit #(.DATA_WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OPRN      (OPRN),
    .OP1       (OP1),
    .OP2       (OP2),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .ZERO      (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: what the operation computes, from its definition.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return ~a;
      3'd4:    return a << sh;
      3'd5:    return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from the accept edge until OUT_VALID is observed (1 = right after accept).
  function automatic int model_latency(input logic [2:0] op, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if ((op == 3'd4 || op == 3'd5) && sh != 0) return int'(sh) + 1;
    return 1;
  endfunction

  task automatic recover_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Runs one request from accept to consumption; called at a negedge with the unit idle.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int stall, input bit interfere);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    bit          seen;
    exp_res = model_result(op, a, b);
    exp_lat = model_latency(op, b);
    seen    = 1'b0;
    lat     = 0;

    vectors++;
    if (IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready_before: got %b want 1", name, IN_READY);
    end

    IN_VALID  = 1'b1;
    OPRN      = op;
    OP1       = a;
    OP2       = b;
    OUT_READY = 1'b0;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    OPRN     = 3'($urandom);
    OP1      = $urandom;
    OP2      = $urandom;

    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      OP1 = $urandom;
      if (OUT_VALID === 1'b1) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end

    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s timeout: no OUT_VALID within 40 cycles, want latency %0d", name, exp_lat);
      recover_reset();
      return;
    end
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end

    vectors++;
    if (RESULT !== exp_res) begin
      miscompares++;
      $display("FAIL %s result: got %h want %h", name, RESULT, exp_res);
    end

    vectors++;
    if (ZERO !== (exp_res == 32'd0)) begin
      miscompares++;
      $display("FAIL %s zero: got %b want %b", name, ZERO, (exp_res == 32'd0));
    end

    vectors++;
    if (IN_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s in_ready_hold: got %b want 0", name, IN_READY);
    end

    for (int s = 0; s < stall; s++) begin
      if (interfere) begin
        IN_VALID = 1'b1;
        OPRN     = 3'($urandom_range(0, 5));
        OP1      = $urandom;
        OP2      = $urandom;
      end
      @(negedge CLK);
      vectors++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || RESULT !== exp_res) begin
        miscompares++;
        $display("FAIL %s stall%0d: got valid=%b ready=%b result=%h want valid=1 ready=0 result=%h",
                 name, s, OUT_VALID, IN_READY, RESULT, exp_res);
      end
    end

    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    IN_VALID  = 1'b0;
    @(negedge CLK);
    vectors++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL %s consume: got valid=%b ready=%b want valid=0 ready=1",
               name, OUT_VALID, IN_READY);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 32'd0 || ZERO !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_init: got valid=%b ready=%b result=%h zero=%b want 0 1 00000000 1",
               OUT_VALID, IN_READY, RESULT, ZERO);
    end
    // Bring the unit to HOLD with a nonzero result, then reset between edges.
    IN_VALID  = 1'b1;
    OPRN      = 3'd1;
    OP1       = 32'hDA00006D;
    OP2       = 32'h0;
    OUT_READY = 1'b0;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    vectors++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 32'd0 || ZERO !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: got valid=%b ready=%b result=%h zero=%b want 0 1 00000000 1",
               OUT_VALID, IN_READY, RESULT, ZERO);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_logic_ops();
    do_op("and_ones", 3'd0, 32'hDA00006D, 32'hFFFFFFFF, 0, 1'b0);
    do_op("or_zero",  3'd1, 32'hDA00006D, 32'h00000000, 0, 1'b0);
    do_op("nor_self", 3'd2, 32'hDA00006D, 32'hDA00006D, 0, 1'b0);
    do_op("not",      3'd3, 32'hDA00006D, 32'h12345678, 0, 1'b0);
    do_op("and_zero", 3'd0, 32'hDA00006D, 32'h00000000, 0, 1'b0);
  endtask

  task automatic test_shifts();
    do_op("sll_31",    3'd4, 32'h00000001, 32'd31,       0, 1'b0);
    do_op("srl_4",     3'd5, 32'hDA00006D, 32'd4,        0, 1'b0);
    do_op("srl_0",     3'd5, 32'hDA00006D, 32'd0,        0, 1'b0);
    do_op("sll_hi_op2",3'd4, 32'hDA00006D, 32'hFFFFFFE3, 0, 1'b0);
    do_op("srl_hi_op2",3'd5, 32'hDA00006D, 32'hFFFFFFE3, 0, 1'b0);
  endtask

  task automatic test_illegal();
    do_op("illegal_110", 3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    do_op("illegal_111", 3'd7, 32'hFFFFFFFF, 32'h0000000F, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_op("bp_and",   3'd0, 32'hDA00006D, 32'hF0F0F0F0, 5, 1'b1);
    do_op("bp_srl",   3'd5, 32'h80000000, 32'd7,        5, 1'b1);
  endtask

  task automatic test_mid_shift_reset();
    IN_VALID  = 1'b1;
    OPRN      = 3'd4;
    OP1       = 32'h0000F00D;
    OP2       = 32'd10;
    OUT_READY = 1'b0;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    vectors++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 32'd0 || ZERO !== 1'b1) begin
      miscompares++;
      $display("FAIL midshift_reset: got valid=%b ready=%b result=%h zero=%b want 0 1 00000000 1",
               OUT_VALID, IN_READY, RESULT, ZERO);
    end
    @(negedge CLK);
    RST = 1'b0;
    // The aborted shift must never surface a result.
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      vectors++;
      if (OUT_VALID !== 1'b0) begin
        miscompares++;
        $display("FAIL midshift_no_valid%0d: got %b want 0", c, OUT_VALID);
      end
    end
    do_op("post_reset_and", 3'd0, 32'hDA00006D, 32'h0F0F0F0F, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_a", 3'd2, 32'h0000FFFF, 32'hFF000000, 0, 1'b0);
    do_op("b2b_b", 3'd4, 32'hDA00006D, 32'd1,        0, 1'b0);
    do_op("b2b_c", 3'd1, 32'h00000000, 32'h00000000, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'd0;
      do_op($sformatf("rand%0d", i), op, a, b, int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    OPRN      = 3'd0;
    OP1       = 32'd0;
    OP2       = 32'd0;
    OUT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset_pre();
    RST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_logic_ops();
    test_shifts();
    test_illegal();
    test_backpressure();
    test_mid_shift_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // While reset is held the unit must show its reset values.
  task automatic test_reset_pre();
    vectors++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 32'd0 || ZERO !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_held: got valid=%b ready=%b result=%h zero=%b want 0 1 00000000 1",
               OUT_VALID, IN_READY, RESULT, ZERO);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
